uart_receiver: RTL and testbench

Serial receive path of the FPGA–ESP8266 UART link: the counterpart of the transmitter timing/shift path. Synchronises the asynchronous `rx` line into the `BCLK` domain, detects and validates start bits by oversampling, and deserialises LSB-first data frames with optional parity. Delivers each byte through a level-valid / read-acknowledge interface with per-frame framing, parity and overrun status.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 39 +++
 rtl/uart_receiver.sv | 158 +++++++++++++++
 tb/tb_uart_receiver.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths.
//   uart_state_t        : receiver FSM state encoding (IDLE=0 .. STOP=4)
//   DEFAULT_OVERSAMPLE  : default sample_tick pulses per bit period
//   DEFAULT_DATA_BITS   : default data bits per frame
//   PARITY_EVEN/ODD     : parity-mode selector values
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int unsigned DEFAULT_OVERSAMPLE = 16;
    localparam int unsigned DEFAULT_DATA_BITS  = 8;

    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receive line.
//   BCLK        in  system clock
//   RST_N       in  asynchronous active-low reset
//   sample_tick in  oversampling enable pulse
//   rx          in  asynchronous serial line (idles high)
//   rx_s        out rx after a 2-flop synchroniser
//   rx_prev     out rx_s as it was on the previous sample tick
//   fall        out falling edge of rx_s seen on the current sample tick
module uart_rx_sync (
    input  logic BCLK,
    input  logic RST_N,
    input  logic sample_tick,
    input  logic rx,
    output logic rx_s,
    output logic rx_prev,
    output logic fall
);

    logic meta;

    // All stages reset high so that reset release never looks like a start bit.
    always_ff @(posedge BCLK or negedge RST_N) begin
        if (!RST_N) begin
            meta    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
            if (sample_tick) begin
                rx_prev <= rx_s;
            end
        end
    end

    // rx_prev must have been high, so a line held low never retriggers.
    assign fall = sample_tick & rx_prev & ~rx_s;

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: start-bit validation by oversampling, LSB-first
// deserialisation with optional parity, and a level-valid / read-ack output.
//   BCLK          in  system clock
//   RST_N         in  asynchronous active-low reset
//   sample_tick   in  one-cycle enable at OVERSAMPLE x baud
//   rx            in  asynchronous serial input
//   rx_read       in  consumer acknowledge pulse
//   rx_data       out last accepted byte (right-aligned)
//   rx_valid      out rx_data is unread
//   signal_busy   out FSM is not IDLE
//   framing_error out stop bit of the last delivered frame was low
//   parity_error  out parity mismatch on the last delivered frame
//   overrun_error out a frame completed while rx_valid was high
module uart_receiver #(
    parameter int unsigned DATA_BITS  = uart_pkg::DEFAULT_DATA_BITS,
    parameter int unsigned OVERSAMPLE = uart_pkg::DEFAULT_OVERSAMPLE,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = uart_pkg::PARITY_EVEN
) (
    input  logic                 BCLK,
    input  logic                 RST_N,
    input  logic                 sample_tick,
    input  logic                 rx,
    input  logic                 rx_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 signal_busy,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 overrun_error
);

    import uart_pkg::*;

    localparam int unsigned    TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_t          state;
    logic [TW-1:0]        tick_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 fall;

    uart_rx_sync u_sync (
        .BCLK        (BCLK),
        .RST_N       (RST_N),
        .sample_tick (sample_tick),
        .rx          (rx),
        .rx_s        (rx_s),
        .rx_prev     (rx_prev),
        .fall        (fall)
    );

    always_ff @(posedge BCLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_bad       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            signal_busy   <= 1'b0;
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            // Consumer acknowledge; a completion later in this block overrides it.
            if (rx_read && rx_valid) begin
                rx_valid      <= 1'b0;
                framing_error <= 1'b0;
                parity_error  <= 1'b0;
                overrun_error <= 1'b0;
            end

            if (sample_tick) begin
                case (state)
                    IDLE: begin
                        if (fall) begin
                            state       <= START;
                            tick_cnt    <= '0;
                            signal_busy <= 1'b1;
                        end
                    end

                    START: begin
                        if (tick_cnt == MID_TICK) begin
                            if (rx_s) begin
                                state       <= IDLE;
                                signal_busy <= 1'b0;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                par_bad  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == LAST_BIT) begin
                                state <= PARITY_EN ? PARITY : STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    PARITY: begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            par_bad  <= (^shreg) ^ rx_s ^ PARITY_ODD;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    STOP: begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt    <= '0;
                            state       <= IDLE;
                            signal_busy <= 1'b0;
                            if (!rx_valid || rx_read) begin
                                rx_data       <= shreg;
                                rx_valid      <= 1'b1;
                                framing_error <= ~rx_s;
                                parity_error  <= par_bad;
                                overrun_error <= 1'b0;
                            end else begin
                                overrun_error <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state       <= IDLE;
                        signal_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: an 8N1 instance (dut0) and an 8E1
// instance (dut1) share the clock, tick and reset. Each frame sent pushes
// the expected output snapshot; a monitor pops it whenever signal_busy falls.
module tb_uart_receiver;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       ov;
    } snap_t;

    logic            BCLK;
    logic            RST_N;
    logic            sample_tick;
    logic [1:0]      rx;
    logic [1:0]      rx_read;
    logic [1:0][7:0] rx_data;
    logic [1:0]      rx_valid;
    logic [1:0]      signal_busy;
    logic [1:0]      framing_error;
    logic [1:0]      parity_error;
    logic [1:0]      overrun_error;

    int errors = 0;
    int checks = 0;

    snap_t m [2];
    snap_t q0 [$];
    snap_t q1 [$];

    uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .BCLK(BCLK), .RST_N(RST_N), .sample_tick(sample_tick), .rx(rx[0]), .rx_read(rx_read[0]),
        .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .signal_busy(signal_busy[0]),
        .framing_error(framing_error[0]), .parity_error(parity_error[0]),
        .overrun_error(overrun_error[0])
    );

    uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .BCLK(BCLK), .RST_N(RST_N), .sample_tick(sample_tick), .rx(rx[1]), .rx_read(rx_read[1]),
        .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .signal_busy(signal_busy[1]),
        .framing_error(framing_error[1]), .parity_error(parity_error[1]),
        .overrun_error(overrun_error[1])
    );

    initial begin
        BCLK = 1'b0;
        forever #5 BCLK = ~BCLK;
    end

    // sample_tick: one BCLK in four, changed on the falling edge.
    initial begin
        int phase;
        phase = 0;
        sample_tick = 1'b0;
        forever begin
            @(negedge BCLK);
            sample_tick = (phase == 3);
            phase = (phase + 1) % 4;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_outputs(input int i, input snap_t e, input string tag);
        chk($sformatf("dut%0d %s valid", i, tag), 32'(rx_valid[i]), 32'(e.v));
        chk($sformatf("dut%0d %s data", i, tag), 32'(rx_data[i]), 32'(e.d));
        chk($sformatf("dut%0d %s framing", i, tag), 32'(framing_error[i]), 32'(e.fe));
        chk($sformatf("dut%0d %s parity", i, tag), 32'(parity_error[i]), 32'(e.pe));
        chk($sformatf("dut%0d %s overrun", i, tag), 32'(overrun_error[i]), 32'(e.ov));
    endtask

    // Monitor: every end of activity (frame done or false start) consumes one expectation.
    initial begin
        logic [1:0] bprev;
        snap_t e;
        bprev = '0;
        forever begin
            @(negedge BCLK);
            for (int i = 0; i < 2; i++) begin
                if (RST_N && bprev[i] && !signal_busy[i]) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d unexpected busy end: got an extra event, expected none", i);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        compare_outputs(i, e, "frame");
                    end
                end
            end
            bprev = signal_busy;
        end
    end

    task automatic push_expect(input int i);
        if (i == 0) q0.push_back(m[0]);
        else        q1.push_back(m[1]);
    endtask

    // Reference model of one completed frame. Even parity: data ones plus
    // the parity bit must be an even count.
    task automatic model_frame(input int i, input logic [7:0] d, input logic par,
                               input logic stop, input bit read_now);
        logic mis;
        mis = (i == 1) ? ((($countones(d) + int'(par)) % 2) != 0) : 1'b0;
        if (!m[i].v || read_now) begin
            m[i].v  = 1'b1;
            m[i].d  = d;
            m[i].fe = ~stop;
            m[i].pe = mis;
            m[i].ov = 1'b0;
        end else begin
            m[i].ov = 1'b1;
        end
        push_expect(i);
    endtask

    task automatic wait_tick();
        @(posedge BCLK);
        while (!sample_tick) @(posedge BCLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d %s data", i, tag), 32'(rx_data[i]), 32'h0);
            chk($sformatf("dut%0d %s valid", i, tag), 32'(rx_valid[i]), 32'h0);
            chk($sformatf("dut%0d %s busy", i, tag), 32'(signal_busy[i]), 32'h0);
            chk($sformatf("dut%0d %s flags", i, tag),
                32'({framing_error[i], parity_error[i], overrun_error[i]}), 32'h0);
        end
    endtask

    // Starts right after a tick edge; every bit lasts 16 ticks. With
    // read_now, rx_read is high only on the BCLK edge that samples the stop bit.
    task automatic send(input int i, input logic [7:0] d, input logic par, input logic stop,
                        input bit read_now, input int abort_bit);
        int nb;
        logic [8:0] bits;
        nb = (i == 1) ? 9 : 8;
        bits = {par, d};
        rx[i] = 1'b0;
        for (int j = 0; j < nb; j++) begin
            idle(16);
            rx[i] = bits[j];
            if (j == abort_bit) begin
                idle(8);
                RST_N = 1'b0;
                rx[i] = 1'b1;
                m[0] = '0;
                m[1] = '0;
                repeat (3) @(posedge BCLK);
                #1;
                check_reset_values("reset mid-frame");
                RST_N = 1'b1;
                return;
            end
        end
        idle(16);
        rx[i] = stop;
        model_frame(i, d, par, stop, read_now);
        idle(8);
        repeat (3) @(posedge BCLK);
        #1;
        if (read_now) rx_read[i] = 1'b1;
        @(posedge BCLK);
        #1;
        rx_read[i] = 1'b0;
        idle(7);
    endtask

    task automatic false_start(input int i);
        push_expect(i);
        rx[i] = 1'b0;
        idle(5);
        rx[i] = 1'b1;
        idle(12);
    endtask

    task automatic do_read(input int i);
        @(posedge BCLK);
        #1;
        rx_read[i] = 1'b1;
        @(posedge BCLK);
        #1;
        rx_read[i] = 1'b0;
        if (m[i].v) begin
            m[i].v  = 1'b0;
            m[i].fe = 1'b0;
            m[i].pe = 1'b0;
            m[i].ov = 1'b0;
        end
        compare_outputs(i, m[i], "after read");
        wait_tick();
    endtask

    initial begin
        int sel;
        logic [7:0] d;
        logic par;
        logic stop;
        int mode;

        RST_N   = 1'b0;
        rx      = '1;
        rx_read = '0;
        m[0]    = '0;
        m[1]    = '0;
        repeat (4) @(posedge BCLK);
        #1;
        check_reset_values("reset");
        RST_N = 1'b1;
        idle(3);

        // Clean 8N1 frame then read.
        send(0, 8'h55, 1'b0, 1'b1, 1'b0, -1);
        idle(2);
        do_read(0);

        // False starts on both instances.
        false_start(0);
        false_start(1);

        // Framing error followed by a held-low break.
        send(0, 8'hA3, 1'b0, 1'b0, 1'b0, -1);
        idle(40);
        chk("dut0 busy during break", 32'(signal_busy[0]), 32'h0);
        rx[0] = 1'b1;
        idle(3);
        chk("dut0 busy after break", 32'(signal_busy[0]), 32'h0);
        do_read(0);

        // Even parity: good then bad parity bit.
        send(1, 8'h07, 1'b1, 1'b1, 1'b0, -1);
        idle(2);
        do_read(1);
        send(1, 8'h07, 1'b0, 1'b1, 1'b0, -1);
        idle(2);
        do_read(1);

        // Overrun, then read coinciding with the second completion.
        send(0, 8'h11, 1'b0, 1'b1, 1'b0, -1);
        send(0, 8'h22, 1'b0, 1'b1, 1'b0, -1);
        idle(2);
        do_read(0);
        send(0, 8'h11, 1'b0, 1'b1, 1'b0, -1);
        send(0, 8'h22, 1'b0, 1'b1, 1'b1, -1);
        idle(2);
        do_read(0);

        // Reset during data bit 4, then a normal frame.
        idle(2);
        send(0, 8'hFF, 1'b0, 1'b1, 1'b0, 4);
        idle(3);
        send(0, 8'h3C, 1'b0, 1'b1, 1'b0, -1);
        idle(2);
        do_read(0);

        // Randomised traffic.
        for (int n = 0; n < 24; n++) begin
            sel  = int'($urandom_range(0, 1));
            d    = 8'($urandom);
            par  = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 7) != 0);
            mode = int'($urandom_range(0, 3));
            if (mode == 0) do_read(sel);
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 20)));
            send(sel, d, par, stop, mode == 1, -1);
            if (!stop) begin
                rx[sel] = 1'b1;
                idle(2);
            end
        end
        idle(4);
        do_read(0);
        do_read(1);

        chk("dut0 pending expectations", 32'(q0.size()), 32'h0);
        chk("dut1 pending expectations", 32'(q1.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
